unidade_funcional_soma: RTL

- Add/sub functional unit directly downstream of the add/sub reservation station.
- Accepts one ready operand pair per cycle (tag, op, Vj, Vk) and computes the result through a fixed-latency pipeline.
- Queues each result in an output buffer, requests the common data bus (CDB) and broadcasts tag+data once granted.
- Credit-based acceptance: the pipeline never stalls and no result is ever dropped.

---
 rtl/unidade_funcional_soma.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/unidade_funcional_soma.sv
// Add/sub functional unit: fixed-latency pipeline feeding a credit-guarded result FIFO that drains onto the CDB.
// Optional feature: define OVERFLOW_FLAG_EN to add a per-result signed-overflow flag (overflowCDB).
module unidade_funcional_soma #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned TAG_W    = 3,
    parameter int unsigned LATENCY  = 2,
    parameter int unsigned OB_DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             dadoPronto,
    input  logic [WIDTH-1:0] operandoA,
    input  logic [WIDTH-1:0] operandoB,
    input  logic             operation,
    input  logic [TAG_W-1:0] nameIn,
    output logic             aceita,
    output logic             pedidoCDB,
    input  logic             concedidoCDB,
    output logic             teveEscritaCDB,
    output logic [TAG_W-1:0] nameCDB,
    output logic [WIDTH-1:0] dadoCDB
`ifdef OVERFLOW_FLAG_EN
    ,
    output logic             overflowCDB
`endif
);

    localparam int unsigned CNT_W = $clog2(OB_DEPTH + LATENCY + 1);
    localparam int unsigned PTR_W = $clog2(OB_DEPTH);

    logic             take;
    logic [WIDTH-1:0] result;
    logic             push_v;
    logic [TAG_W-1:0] push_tag;
    logic [WIDTH-1:0] push_data;
    logic [CNT_W-1:0] inflight;
    logic [CNT_W-1:0] ob_count;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             pop;
    logic [TAG_W-1:0] ob_tag  [OB_DEPTH];
    logic [WIDTH-1:0] ob_data [OB_DEPTH];
`ifdef OVERFLOW_FLAG_EN
    logic             res_ovf;
    logic             push_ovf;
    logic             ob_ovf  [OB_DEPTH];
`endif

    // Credit check: every in-flight op already owns a buffer slot.
    assign aceita    = (inflight + ob_count) < CNT_W'(OB_DEPTH);
    assign pedidoCDB = (ob_count != '0);
    assign take      = dadoPronto & aceita;
    assign pop       = pedidoCDB & concedidoCDB;
    assign result    = operation ? (operandoA - operandoB) : (operandoA + operandoB);
`ifdef OVERFLOW_FLAG_EN
    assign res_ovf = (operation ? (operandoA[WIDTH-1] ^ operandoB[WIDTH-1])
                                : ~(operandoA[WIDTH-1] ^ operandoB[WIDTH-1]))
                     & (result[WIDTH-1] ^ operandoA[WIDTH-1]);
`endif

    // Stage 1 computes; remaining LATENCY-1 stages are registered delay before the buffer.
    generate
        if (LATENCY == 1) begin : g_nopipe
            assign push_v    = take;
            assign push_tag  = nameIn;
            assign push_data = result;
            assign inflight  = '0;
`ifdef OVERFLOW_FLAG_EN
            assign push_ovf  = res_ovf;
`endif
        end else begin : g_pipe
            localparam int unsigned PD = LATENCY - 1;
            logic [PD-1:0]    pv;
            logic [TAG_W-1:0] ptag  [PD];
            logic [WIDTH-1:0] pdata [PD];
`ifdef OVERFLOW_FLAG_EN
            logic             povf  [PD];
`endif

            always_ff @(posedge clock) begin
                if (reset) begin
                    pv <= '0;
                end else begin
                    pv[0] <= take;
                    for (int i = 1; i < int'(PD); i++) pv[i] <= pv[i-1];
                end
            end

            always_ff @(posedge clock) begin
                ptag[0]  <= nameIn;
                pdata[0] <= result;
`ifdef OVERFLOW_FLAG_EN
                povf[0]  <= res_ovf;
`endif
                for (int i = 1; i < int'(PD); i++) begin
                    ptag[i]  <= ptag[i-1];
                    pdata[i] <= pdata[i-1];
`ifdef OVERFLOW_FLAG_EN
                    povf[i]  <= povf[i-1];
`endif
                end
            end

            always_comb begin
                inflight = '0;
                for (int i = 0; i < int'(PD); i++) inflight = inflight + CNT_W'(pv[i]);
            end

            assign push_v    = pv[PD-1];
            assign push_tag  = ptag[PD-1];
            assign push_data = pdata[PD-1];
`ifdef OVERFLOW_FLAG_EN
            assign push_ovf  = povf[PD-1];
`endif
        end
    endgenerate

    // Result FIFO control: circular pointers, count tracks push/pop together.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ob_count <= '0;
        end else begin
            if (push_v) wr_ptr <= (wr_ptr == PTR_W'(OB_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            if (pop)    rd_ptr <= (rd_ptr == PTR_W'(OB_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            ob_count <= ob_count + CNT_W'(push_v) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (push_v) begin
            ob_tag[wr_ptr]  <= push_tag;
            ob_data[wr_ptr] <= push_data;
`ifdef OVERFLOW_FLAG_EN
            ob_ovf[wr_ptr]  <= push_ovf;
`endif
        end
    end

    // CDB broadcast register: one-cycle valid pulse, payload holds between grants.
    always_ff @(posedge clock) begin
        if (reset) begin
            teveEscritaCDB <= 1'b0;
            nameCDB        <= '0;
            dadoCDB        <= '0;
`ifdef OVERFLOW_FLAG_EN
            overflowCDB    <= 1'b0;
`endif
        end else begin
            teveEscritaCDB <= pop;
            if (pop) begin
                nameCDB     <= ob_tag[rd_ptr];
                dadoCDB     <= ob_data[rd_ptr];
`ifdef OVERFLOW_FLAG_EN
                overflowCDB <= ob_ovf[rd_ptr];
`endif
            end
        end
    end

endmodule
